// File: rtl/axis_buffered_reduce_if.sv
// rtl/axis_buffered_reduce_if.sv - AXI-Stream style handshake bundle with master/slave views
interface axis_buffered_reduce_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_buffered_reduce.sv
// rtl/axis_buffered_reduce.sv - packet buffer emitting sum/max reduction plus status, or reversed echo
module axis_buffered_reduce #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [1:0]              mode,
  axis_buffered_reduce_if.slave   s_axis,
  axis_buffered_reduce_if.master  m_axis
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {RECV, SEND_RED, SEND_ECHO} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         count, count_nx, count_inc;
  logic [DATA_WIDTH-1:0] acc, acc_nx;
  logic [DATA_WIDTH-1:0] tdata_r, tdata_nx, status;
  logic [DATA_WIDTH:0]   sum;
  logic [1:0]            mode_r, mode_nx, eff_mode;
  logic [AW-1:0]         rd_idx, rd_idx_nx;
  logic                  ovf, ovf_nx, trunc, trunc_nx;
  logic                  tvalid_r, tvalid_nx, tlast_r, tlast_nx;
  logic                  s_ready_r, s_ready_nx;
  logic                  s_fire, m_fire, closing;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign s_axis.tready = s_ready_r;
  assign m_axis.tvalid = tvalid_r;
  assign m_axis.tdata  = tdata_r;
  assign m_axis.tlast  = tlast_r;

  assign s_fire = s_ready_r && s_axis.tvalid;
  assign m_fire = tvalid_r && m_axis.tready;

  always_comb begin
    status                 = '0;
    status[DATA_WIDTH-1]   = ovf;
    status[DATA_WIDTH-2]   = trunc;
    status[CW-1:0]         = count;
  end

  always_ff @(posedge aclk) begin
    if (s_fire) mem[count[AW-1:0]] <= s_axis.tdata;
  end

  always_comb begin
    state_nx  = state;
    count_nx  = count;
    acc_nx    = acc;
    ovf_nx    = ovf;
    trunc_nx  = trunc;
    mode_nx   = mode_r;
    rd_idx_nx = rd_idx;
    tvalid_nx = tvalid_r;
    tdata_nx  = tdata_r;
    tlast_nx  = tlast_r;
    eff_mode  = (count == '0) ? mode : mode_r;
    sum       = {1'b0, acc} + {1'b0, s_axis.tdata};
    count_inc = count + 1'b1;
    closing   = s_axis.tlast || (count_inc == CW'(DEPTH));

    case (state)
      RECV: begin
        if (s_fire) begin
          count_nx = count_inc;
          mode_nx  = eff_mode;
          if (eff_mode == 2'd1) begin
            acc_nx = (count == '0 || s_axis.tdata > acc) ? s_axis.tdata : acc;
          end else begin
            acc_nx = sum[DATA_WIDTH-1:0];
            if (eff_mode != 2'd2) ovf_nx = ovf | sum[DATA_WIDTH];
          end
          if (closing) begin
            trunc_nx  = !s_axis.tlast;
            tvalid_nx = 1'b1;
            if (eff_mode == 2'd2) begin
              // The newest word is still being written, so present it straight from the input.
              state_nx  = SEND_ECHO;
              tdata_nx  = s_axis.tdata;
              tlast_nx  = (count == '0);
              rd_idx_nx = count[AW-1:0];
            end else begin
              state_nx = SEND_RED;
              tdata_nx = acc_nx;
              tlast_nx = 1'b0;
            end
          end
        end
      end
      SEND_RED: begin
        if (m_fire && !tlast_r) begin
          tdata_nx = status;
          tlast_nx = 1'b1;
        end
      end
      SEND_ECHO: begin
        if (m_fire && !tlast_r) begin
          rd_idx_nx = rd_idx - 1'b1;
          tdata_nx  = mem[rd_idx_nx];
          tlast_nx  = (rd_idx_nx == '0);
        end
      end
      default: state_nx = RECV;
    endcase

    if (state != RECV && m_fire && tlast_r) begin
      state_nx  = RECV;
      count_nx  = '0;
      acc_nx    = '0;
      ovf_nx    = 1'b0;
      trunc_nx  = 1'b0;
      tvalid_nx = 1'b0;
      tdata_nx  = '0;
      tlast_nx  = 1'b0;
    end

    // Registered ready also gives the one-edge delay after reset release.
    s_ready_nx = (state_nx == RECV);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= RECV;
      count     <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      trunc     <= 1'b0;
      mode_r    <= 2'd0;
      rd_idx    <= '0;
      tvalid_r  <= 1'b0;
      tdata_r   <= '0;
      tlast_r   <= 1'b0;
      s_ready_r <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      acc       <= acc_nx;
      ovf       <= ovf_nx;
      trunc     <= trunc_nx;
      mode_r    <= mode_nx;
      rd_idx    <= rd_idx_nx;
      tvalid_r  <= tvalid_nx;
      tdata_r   <= tdata_nx;
      tlast_r   <= tlast_nx;
      s_ready_r <= s_ready_nx;
    end
  end
endmodule

// File: tb/tb_axis_buffered_reduce.sv
// tb/tb_axis_buffered_reduce.sv - directed and random packets checked against a packet-level model
module tb_axis_buffered_reduce;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [1:0] mode;

  axis_buffered_reduce_if #(.DATA_WIDTH(DW)) s_if ();
  axis_buffered_reduce_if #(.DATA_WIDTH(DW)) m_if ();

  axis_buffered_reduce #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .mode    (mode),
    .s_axis  (s_if),
    .m_axis  (m_if)
  );

  always #5 aclk = ~aclk;

  typedef struct {logic [DW-1:0] data; logic last; logic [1:0] mode;} beat_t;
  typedef struct {logic [DW-1:0] data; logic last;} obeat_t;

  beat_t  in_q[$];
  obeat_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     valid_pct = 100;
  int     ready_pct = 100;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [1:0] md, input logic [DW-1:0] d, input logic l);
    in_q.push_back('{d, l, md});
  endtask

  // Reference result of one closed packet: reversed words, or reduction followed by status.
  function automatic void emit(input logic [DW-1:0] w[$], input logic [1:0] md, input logic tr);
    longint unsigned tot = 0;
    logic [DW-1:0]   mx = '0;
    logic [DW-1:0]   st;
    if (md == 2'd2) begin
      for (int i = w.size() - 1; i >= 0; i--) exp_q.push_back('{w[i], (i == 0)});
    end else begin
      foreach (w[i]) begin
        tot += longint'(w[i]);
        if (w[i] > mx) mx = w[i];
      end
      st     = DW'(w.size());
      st[31] = (md != 2'd1) && (tot >= 64'h1_0000_0000);
      st[30] = tr;
      exp_q.push_back('{(md == 2'd1) ? mx : tot[31:0], 1'b0});
      exp_q.push_back('{st, 1'b1});
    end
  endfunction

  function automatic void build_expected();
    logic [DW-1:0] cur[$];
    logic [1:0]    cur_mode = 2'd0;
    exp_q.delete();
    foreach (in_q[i]) begin
      if (cur.size() == 0) cur_mode = in_q[i].mode;
      cur.push_back(in_q[i].data);
      if (in_q[i].last || cur.size() == DEPTH) begin
        emit(cur, cur_mode, !in_q[i].last);
        cur.delete();
      end
    end
  endfunction

  task automatic run_stream(input string tag);
    int            idx = 0;
    int            cyc = 0;
    logic          stall = 1'b0;
    logic [DW-1:0] pd = '0;
    logic          pl = 1'b0;
    obeat_t        e;
    build_expected();
    while ((idx < in_q.size() || exp_q.size() > 0) && cyc < 5000) begin
      @(negedge aclk);
      cyc++;
      if (stall) begin
        chk({tag, " hold_valid"}, m_if.tvalid, 1'b1);
        chk({tag, " hold_data"}, m_if.tdata, pd);
        chk({tag, " hold_last"}, m_if.tlast, pl);
      end
      if (m_if.tvalid) chk({tag, " s_ready_in_send"}, s_if.tready, 1'b0);
      if (idx < in_q.size() && $urandom_range(99) < valid_pct) begin
        s_if.tvalid = 1'b1;
        s_if.tdata  = in_q[idx].data;
        s_if.tlast  = in_q[idx].last;
        mode        = in_q[idx].mode;
      end else begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = $urandom;
        s_if.tlast  = 1'($urandom);
        mode        = 2'($urandom);
      end
      m_if.tready = ($urandom_range(99) < ready_pct);
      if (s_if.tvalid && s_if.tready) idx++;
      stall = 1'b0;
      if (m_if.tvalid) begin
        if (!m_if.tready) begin
          stall = 1'b1;
          pd    = m_if.tdata;
          pl    = m_if.tlast;
        end else if (exp_q.size() == 0) begin
          chk({tag, " extra_beat"}, m_if.tvalid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk({tag, " data"}, m_if.tdata, e.data);
          chk({tag, " last"}, m_if.tlast, e.last);
        end
      end
    end
    if (cyc >= 5000) chk({tag, " timeout_pending"}, 32'(exp_q.size()), 32'd0);
    @(negedge aclk);
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    chk({tag, " idle_valid"}, m_if.tvalid, 1'b0);
    chk({tag, " idle_s_ready"}, s_if.tready, 1'b1);
    in_q.delete();
  endtask

  initial begin
    int w;
    int len;
    logic [1:0] md;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    mode        = 2'd0;

    repeat (3) @(negedge aclk);
    chk("rst m_valid", m_if.tvalid, 1'b0);
    chk("rst m_data", m_if.tdata, '0);
    chk("rst m_last", m_if.tlast, 1'b0);
    chk("rst s_ready", s_if.tready, 1'b0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst s_ready", s_if.tready, 1'b1);

    push(0, 32'h0000fe40, 0); push(0, 32'h00046000, 1);
    run_stream("sum");
    push(1, 32'd5, 0); push(1, 32'hFFFFFFF0, 0); push(1, 32'd7, 1);
    run_stream("max");
    push(0, 32'hFFFFFFFF, 0); push(0, 32'h00000002, 1);
    run_stream("wrap");
    push(2, 32'd1, 0); push(2, 32'd2, 0); push(2, 32'd3, 0); push(2, 32'd4, 1);
    run_stream("echo");
    for (int i = 0; i < 17; i++) push(0, 32'd1, (i == 16));
    run_stream("trunc");
    for (int i = 0; i < 16; i++) push(2, 32'(i + 100), (i == 15));
    run_stream("full_echo");
    push(3, 32'd9, 1); push(2, 32'h55, 1); push(1, 32'h0, 1);
    run_stream("single");
    push(0, 32'd10, 0); push(1, 32'd3, 0); push(2, 32'd4, 1);
    run_stream("mode_latch");

    valid_pct = 70;
    ready_pct = 60;
    for (int r = 0; r < 5; r++) begin
      for (int p = 0; p < 5; p++) begin
        md  = 2'($urandom_range(3));
        len = $urandom_range(1, 20);
        for (int i = 0; i < len; i++)
          push((i == 0) ? md : 2'($urandom_range(3)),
               ($urandom_range(3) == 0) ? (32'hFFFFFF00 | 32'($urandom_range(255))) : $urandom,
               (i == len - 1));
      end
      run_stream("random");
    end
    valid_pct = 100;
    ready_pct = 100;

    @(negedge aclk);
    s_if.tvalid = 1'b1; s_if.tdata = 32'h11; s_if.tlast = 1'b0; mode = 2'd0;
    @(negedge aclk);
    s_if.tdata = 32'h22; s_if.tlast = 1'b1;
    @(negedge aclk);
    s_if.tvalid = 1'b0;
    w = 0;
    while (!m_if.tvalid && w < 20) begin
      @(negedge aclk);
      w++;
    end
    chk("bp first_valid", m_if.tvalid, 1'b1);
    chk("bp first_data", m_if.tdata, 32'h33);
    repeat (3) begin
      @(negedge aclk);
      chk("bp held_valid", m_if.tvalid, 1'b1);
      chk("bp held_data", m_if.tdata, 32'h33);
      chk("bp held_last", m_if.tlast, 1'b0);
    end
    #2 aresetn = 1'b0;
    #1;
    chk("midrst m_valid", m_if.tvalid, 1'b0);
    chk("midrst m_data", m_if.tdata, '0);
    chk("midrst m_last", m_if.tlast, 1'b0);
    chk("midrst s_ready", s_if.tready, 1'b0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rel s_ready", s_if.tready, 1'b1);
    chk("rel m_valid", m_if.tvalid, 1'b0);
    push(1, 32'd9, 1);
    run_stream("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
